// File: rtl/onehot_decoder_scan.sv
// Registered binary-to-one-hot decoder with a direct (valid/ready) mode and an autonomous scan sweep.
// Outputs change one cycle after inputs are sampled. in_ready is the only combinational output.
module onehot_decoder_scan #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       sel,
    output logic [(1<<SEL_W)-1:0]  dec_out,
    output logic                   out_valid,
    output logic [SEL_W-1:0]       cur_sel,
    output logic                   wrap
);
    localparam int LINES = 1 << SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  dec_q, dec_d;
    logic              vld_q, vld_d;
    logic [SEL_W-1:0]  cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic              accept;

    assign in_ready = en & ~mode & ~rst;
    assign accept   = in_valid & in_ready;

    function automatic logic [LINES-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [LINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        dec_d   = '0;
        vld_d   = 1'b0;
        wrap_d  = 1'b0;
        // With en low everything holds and the output blanks; a mode change outranks an accept.
        if (en) begin
            case (state_q)
                IDLE, DIRECT: begin
                    if (mode) begin
                        state_d = SCAN;
                        cur_d   = '0;
                        cnt_d   = '0;
                    end else if (accept) begin
                        state_d = DIRECT;
                        cur_d   = sel;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        state_d = accept ? DIRECT : IDLE;
                        if (accept) begin
                            cur_d = sel;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        cur_d  = cur_q + 1'b1;
                        wrap_d = (cur_q == '1);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_d != IDLE) begin
                dec_d = onehot(cur_d);
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dec_q   <= '0;
            vld_q   <= 1'b0;
            cur_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            vld_q   <= vld_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign dec_out   = dec_q;
    assign out_valid = vld_q;
    assign cur_sel   = cur_q;
    assign wrap      = wrap_q;
endmodule

// File: tb/tb_onehot_decoder_scan.sv
// Scoreboard bench: four decoder configurations share stimulus; a reference model predicts every cycle.
module tb_onehot_decoder_scan;
    localparam int SW [4] = '{2, 2, 1, 6};
    localparam int DW [4] = '{3, 1, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, mode, in_valid;
    logic [5:0] sel6;

    logic [3:0]  dec_a, dec_b;
    logic [1:0]  dec_c;
    logic [63:0] dec_d;
    logic [1:0]  cur_a, cur_b;
    logic        cur_c;
    logic [5:0]  cur_d;
    logic [3:0]  rdy_v, vld_v, wr_v;

    onehot_decoder_scan #(.SEL_W(SW[0]), .DWELL(DW[0])) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy_v[0]),
        .sel(sel6[1:0]), .dec_out(dec_a), .out_valid(vld_v[0]), .cur_sel(cur_a), .wrap(wr_v[0]));
    onehot_decoder_scan #(.SEL_W(SW[1]), .DWELL(DW[1])) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy_v[1]),
        .sel(sel6[1:0]), .dec_out(dec_b), .out_valid(vld_v[1]), .cur_sel(cur_b), .wrap(wr_v[1]));
    onehot_decoder_scan #(.SEL_W(SW[2]), .DWELL(DW[2])) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy_v[2]),
        .sel(sel6[0]), .dec_out(dec_c), .out_valid(vld_v[2]), .cur_sel(cur_c), .wrap(wr_v[2]));
    onehot_decoder_scan #(.SEL_W(SW[3]), .DWELL(DW[3])) u_d (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy_v[3]),
        .sel(sel6), .dec_out(dec_d), .out_valid(vld_v[3]), .cur_sel(cur_d), .wrap(wr_v[3]));

    logic [63:0] act_dec [4];
    logic [5:0]  act_cur [4];
    assign act_dec[0] = 64'(dec_a);
    assign act_dec[1] = 64'(dec_b);
    assign act_dec[2] = 64'(dec_c);
    assign act_dec[3] = dec_d;
    assign act_cur[0] = 6'(cur_a);
    assign act_cur[1] = 6'(cur_b);
    assign act_cur[2] = 6'(cur_c);
    assign act_cur[3] = cur_d;

    typedef struct packed {
        logic [3:0][63:0] dec;
        logic [3:0]       vld;
        logic [3:0][5:0]  cur;
        logic [3:0]       wr;
    } exp_t;

    exp_t out_q [$];
    bit   rdy_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: 0 = idle, 1 = direct (addressed), 2 = sweeping.
    int m_st [4];
    int m_line [4];
    int m_cnt [4];
    bit m_on [4];
    bit m_wr [4];

    task automatic model_step(input int k, input bit r, input bit e, input bit m, input bit v, input int s);
        int n;
        n = 1 << SW[k];
        m_wr[k] = 1'b0;
        if (r) begin
            m_st[k] = 0; m_line[k] = 0; m_cnt[k] = 0; m_on[k] = 1'b0;
        end else if (!e) begin
            m_on[k] = 1'b0;
        end else if (m_st[k] != 2) begin
            if (m) begin
                m_st[k] = 2; m_line[k] = 0; m_cnt[k] = 0; m_on[k] = 1'b1;
            end else if (v) begin
                m_st[k] = 1; m_line[k] = s % n; m_on[k] = 1'b1;
            end else begin
                m_on[k] = (m_st[k] == 1);
            end
        end else if (!m) begin
            if (v) begin
                m_st[k] = 1; m_line[k] = s % n; m_on[k] = 1'b1;
            end else begin
                m_st[k] = 0; m_on[k] = 1'b0;
            end
        end else begin
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == DW[k]) begin
                m_cnt[k]  = 0;
                m_line[k] = (m_line[k] + 1) % n;
                m_wr[k]   = (m_line[k] == 0);
            end
            m_on[k] = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit m, input bit v, input logic [5:0] s);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; in_valid = v; sel6 = s;
        rdy_q.push_back(e & ~m & ~r);
        for (int k = 0; k < 4; k++) begin
            model_step(k, r, e, m, v, int'(s));
            x.dec[k] = m_on[k] ? (64'd1 << m_line[k]) : 64'd0;
            x.vld[k] = m_on[k];
            x.cur[k] = 6'(m_line[k]);
            x.wr[k]  = m_wr[k];
        end
        out_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        bit   r;
        forever begin
            @(negedge clk);
            #2;
            if (rdy_q.size() > 0) begin
                r = rdy_q.pop_front();
                n_checks++;
                if (rdy_v !== {4{r}}) begin
                    n_fail++;
                    $display("FAIL in_ready t=%0t got=%b want=%b", $time, rdy_v, {4{r}});
                end
            end
            @(posedge clk);
            #2;
            if (out_q.size() > 0) begin
                x = out_q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if ({act_dec[k], vld_v[k], act_cur[k], wr_v[k]} !==
                        {x.dec[k], x.vld[k], x.cur[k], x.wr[k]}) begin
                        n_fail++;
                        $display("FAIL outputs inst=%0d t=%0t got dec=%h vld=%b cur=%0d wrap=%b want dec=%h vld=%b cur=%0d wrap=%b",
                                 k, $time, act_dec[k], vld_v[k], act_cur[k], wr_v[k],
                                 x.dec[k], x.vld[k], x.cur[k], x.wr[k]);
                    end
                    n_checks++;
                    if (!$onehot0(act_dec[k]) || (vld_v[k] !== (|act_dec[k]))) begin
                        n_fail++;
                        $display("FAIL onehot_invariant inst=%0d t=%0t got dec=%h vld=%b want one-hot/zero with vld=|dec",
                                 k, $time, act_dec[k], vld_v[k]);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit m;
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; sel6 = '0;
        for (int k = 0; k < 4; k++) begin
            m_st[k] = 0; m_line[k] = 0; m_cnt[k] = 0; m_on[k] = 1'b0; m_wr[k] = 1'b0;
        end
        // reset then back-to-back accepts
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 1, 6'd2);
        step(0, 1, 0, 1, 6'd0);
        step(0, 1, 0, 1, 6'd3);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        // full sweeps
        repeat (30) step(0, 1, 1, 0, 0);
        // pause during line 1
        step(0, 1, 0, 0, 0);
        repeat (5) step(0, 1, 1, 0, 0);
        repeat (5) step(0, 0, 1, 0, 0);
        repeat (6) step(0, 1, 1, 0, 0);
        // leave scan on line 3 with a same-cycle accept
        step(0, 1, 0, 0, 0);
        repeat (10) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 6'd1);
        repeat (3) step(0, 1, 0, 0, 0);
        // reset mid-scan then long sweep
        repeat (7) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (140) step(0, 1, 1, 0, 0);
        // top line, then enable drop and restore in direct
        step(0, 1, 0, 1, 6'd63);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 6'd5);
        step(0, 0, 0, 1, 6'd5);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        m = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(15) == 0) m = ~m;
            step($urandom_range(99) == 0, $urandom_range(7) != 0, m,
                 $urandom_range(1) == 1, 6'($urandom));
        end
        @(negedge clk);
        @(posedge clk);
        #5;
        n_checks++;
        if (out_q.size() != 0 || rdy_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d/%0d pending want=0/0", out_q.size(), rdy_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/onehot_decoder_scan.md
# onehot_decoder_scan

Parametrised, registered N-to-2^N binary-to-one-hot decoder with a valid/ready input handshake, a global enable, and an autonomous scan mode that steps the active output through every line with a programmable dwell. It is the successor to the team's fixed 2-to-4 combinational decoder. It sits between control logic and multiplexed loads (digit selects, row strobes, chip selects) that need either a directly addressed line or a time-multiplexed sweep.

## Interface
- SEL_W, 2, select width N; legal 1..6; output width is 2**SEL_W
- DWELL, 4, cycles each line stays active in scan mode; legal 1..65535
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable; low blanks the output and pauses scan
- mode  input  1  0 = direct (handshake-addressed), 1 = scan (auto-sweep)
- in_valid  input  1  sel is valid this cycle (direct mode)
- in_ready  output  1  combinational: en & ~mode & ~rst
- sel  input  SEL_W  binary line index, sampled on accept
- dec_out  output  2**SEL_W  registered one-hot (or all-zero) output
- out_valid  output  1  registered; high when dec_out has exactly one bit set
- cur_sel  output  SEL_W  registered binary index of the active line
- wrap  output  1  registered one-cycle pulse when scan returns to line 0

## Operation
- States: IDLE, DIRECT, SCAN. Reset goes to IDLE.
- Reset values: dec_out=0, out_valid=0, cur_sel=0, wrap=0, dwell counter=0, state=IDLE.
- IDLE behaviour:
  - dec_out=0.
  - Accept (in_valid & in_ready) -> DIRECT.
  - en & mode -> SCAN.
- DIRECT behaviour:
  - Accept: next cycle dec_out = 1<<sel, cur_sel=sel, out_valid=1.
  - Without an accept, the output holds indefinitely.
  - A new accept replaces the output the following cycle. Back-to-back accepts are allowed every cycle.
- SCAN entry (en & mode seen in IDLE or DIRECT):
  - Next cycle: dec_out=1, cur_sel=0, out_valid=1, dwell counter=0.
- SCAN stepping:
  - The dwell counter increments each cycle while en=1.
  - When the counter = DWELL-1, it clears and cur_sel advances by 1 at the next edge.
  - Index 2**SEL_W-1 wraps to 0. wrap=1 for exactly the cycle in which dec_out shows line 0 after the wrap.
  - wrap is never asserted on SCAN entry.
- DWELL=1: the line advances every cycle, and wrap pulses once every 2**SEL_W cycles.
- en low, any state:
  - Next cycle: dec_out=0, out_valid=0.
  - cur_sel, dwell counter and state hold.
  - in_valid is ignored (in_ready=0).
- en rising again:
  - In SCAN: resumes at the held cur_sel with the held dwell count; dec_out=1<<cur_sel the next cycle.
  - In DIRECT: restores 1<<cur_sel the next cycle.
- mode 1->0 while in SCAN: next cycle dec_out=0, out_valid=0, state=IDLE. An accept in that same cycle takes priority and goes to DIRECT with 1<<sel.
- mode 0->1 while in DIRECT: re-enters SCAN at line 0.
- Simultaneous events: rst over everything; then en=0; then a mode change; then an accept.
- rst mid-scan or mid-hold: all state returns to reset values at the next edge; no wrap pulse.
- Invariant: dec_out is always all-zero or exactly one-hot; out_valid = |dec_out.

## Timing
- Direct latency: 1 cycle from accept edge to dec_out.
- Scan period: DWELL cycles per line, DWELL*2**SEL_W cycles per full sweep.
- Glitch freedom: all outputs are registered except in_ready.
- Throughput: one accept per cycle in direct mode.
- Reset: in_ready=0 during reset and in the first cycle only if en=0 or mode=1.

## Test plan
- Reset/direct, SEL_W=2:
  - Stimulus: rst for 2 cycles, en=1, mode=0, then accept sel=2, 0, 3 on consecutive cycles.
  - Required: dec_out=0000 during reset, then 0100, 0001, 1000, each 1 cycle after its accept; out_valid=1; cur_sel tracks sel.
- Scan sweep, SEL_W=2, DWELL=3:
  - Stimulus: en=1, mode=1.
  - Required: dec_out=0001 for 3 cycles, then 0010, 0100, 1000 for 3 cycles each, then 0001 with wrap=1 for one cycle only; period 12 cycles.
- Pause, DWELL=3:
  - Stimulus: in scan, drop en for 5 cycles after the 2nd cycle of line 1.
  - Required: dec_out=0000 and out_valid=0 for those 5 cycles; on resume, 0010 lasts 1 more cycle, then 0100.
- Mode switch:
  - Stimulus: in scan on line 3, set mode=0 with in_valid=1, sel=1 in the same cycle.
  - Required: next cycle dec_out=0010, state DIRECT, wrap=0.
- Reset mid-scan, DWELL=1:
  - Stimulus: assert rst during line 2.
  - Required: next cycle all outputs 0.
  - After release with mode=1: restarts at 0001, with no wrap until a full sweep completes.
- Width sweep:
  - Stimulus: SEL_W=1 and SEL_W=6, DWELL=1.
  - Required: dec_out one-hot or zero in every cycle; wrap every 2 and 64 cycles respectively; sel=63 gives bit 63 set.
